// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register file geometry and the writeback request shared by execute and memory
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 24;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bit per register and read-after-write hazard detection
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic [NUM_REGS-1:0] busy,
    output logic                hazard
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_nxt;
    logic [DEPTH-1:0]    busy_ext;

    // a register committing this cycle is readable through the register file, so it is not a hazard
    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            busy_nxt[i] = (set_en && set_addr == ADDR_W'(i)) ||
                          (busy[i] && !(clr_en && clr_addr == ADDR_W'(i)));
        busy_ext = DEPTH'(busy);
        hazard   = (busy_ext[rs1] && !(clr_en && clr_addr == rs1)) ||
                   (busy_ext[rs2] && !(clr_en && clr_addr == rs2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load writeback with starvation guard
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic                alu_req,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_gnt,
    input  logic                mem_req,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_gnt,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic                hazard,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          commit;
    wb_req_t       alu_w, mem_w, win;

    // loads win ties so the memory pipeline drains, until the ALU has lost STARVE_LIMIT times in a row
    always_comb begin
        alu_w   = '{req: alu_req, addr: alu_addr, data: alu_data};
        mem_w   = '{req: mem_req, addr: mem_addr, data: mem_data};
        starved = starve_cnt == CW'(STARVE_LIMIT);
        alu_gnt = rst_n && alu_req && (!mem_req || starved);
        mem_gnt = rst_n && mem_req && !(alu_req && starved);
        win     = alu_gnt ? alu_w : mem_w;
        commit  = (alu_gnt || mem_gnt) && in_range(win.addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            starve_cnt <= '0;
        end else begin
            wr_en      <= commit;
            starve_cnt <= (alu_req && !alu_gnt) ? (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
            if (commit) begin
                wr_addr <= win.addr;
                wr_data <= win.data;
            end
        end
    end

    regfile_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid && in_range(iss_rd)),
        .set_addr (iss_rd),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy     (busy_vec),
        .hazard   (hazard)
    );

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writeback sources: ALU result and memory load.
- Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards.
- Sits between execute/memory stages and the register file. Drives the register file's write_enable, write_address and data_in from registered outputs.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 24, count of architecturally writable registers (addresses 0..NUM_REGS-1); higher addresses read as 0 in the register file
- STARVE_LIMIT, 3, consecutive ALU losses before the ALU is forced to win

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  instruction issued with a destination register
- iss_rd  in  ADDR_W  destination register of the issued instruction
- alu_req  in  1  ALU writeback request
- alu_addr  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- alu_gnt  out  1  ALU request accepted this cycle (combinational)
- mem_req  in  1  load writeback request
- mem_addr  in  ADDR_W  load destination
- mem_data  in  DATA_W  load data
- mem_gnt  out  1  load request accepted this cycle (combinational)
- rs1  in  ADDR_W  decode source 1
- rs2  in  ADDR_W  decode source 2
- hazard  out  1  decode must stall (combinational)
- wr_en  out  1  to register file write_enable (registered)
- wr_addr  out  ADDR_W  to register file write_address (registered)
- wr_data  out  DATA_W  to register file data_in (registered)
- busy_vec  out  NUM_REGS  scoreboard bits, debug/visibility

Behaviour:
- Reset (async, rst_n=0): wr_en=0, wr_addr=0, wr_data=0, busy_vec all 0, starvation counter 0. alu_gnt, mem_gnt and hazard evaluate to 0 while reset is held.
- Arbitration, one grant per cycle:
  - Only one requester asserted: that requester is granted.
  - Both asserted: mem wins, unless starve_cnt==STARVE_LIMIT, in which case alu wins.
- Starvation counter:
  - Increments when alu_req=1 and alu_gnt=0; saturates at STARVE_LIMIT.
  - Clears on any alu grant or when alu_req=0.
- A requester holds req, addr and data stable until granted. The grant is the only acceptance; there is no retraction.
- Commit latency: grant in cycle N gives wr_en=1 with the granted addr/data in cycle N+1. The register file sees exactly one write per granted request. With no grant in cycle N, wr_en=0 in N+1 and wr_addr/wr_data hold their previous values.
- Out-of-range destination (addr >= NUM_REGS): the request is still granted, but wr_en stays 0 for it and no scoreboard bit changes.
- Scoreboard:
  - iss_valid with iss_rd < NUM_REGS sets busy[iss_rd] at the next edge.
  - A commit (wr_en=1 at cycle N+1) clears busy[wr_addr] at the end of N+1.
  - Set and clear of the same register on the same edge: set wins.
  - Set of an already-busy register: stays 1. A single bit per register; the issue stage allows at most one outstanding writer per register.
- Hazard:
  - hazard = (rs1 < NUM_REGS and busy[rs1] and not(wr_en and wr_addr==rs1)) or the same term for rs2.
  - A register being written this cycle is not a hazard, because the register file reads combinationally after the write.
  - Addresses >= NUM_REGS never raise a hazard.
- Reset mid-operation: all pending grants, scoreboard bits and the in-flight commit are discarded immediately; no write reaches the register file after rst_n falls.

Decomposition:
- Shared package: DATA_W, ADDR_W and NUM_REGS constants, plus a wb_req typedef (req, addr, data) used by execute and memory stages.
- One natural sub-module: regfile_scoreboard (busy bits, set/clear priority, hazard compare).
- Arbitration, starvation counter and output registers stay in the top.

Test Plan:
- Reset: hold rst_n=0 with alu_req=1 -> wr_en=0, busy_vec=0, alu_gnt=0; release -> alu_gnt=1 the same cycle, wr_en=1 one cycle later.
- Single ALU write: alu_req=1, alu_addr=5, alu_data=0xDEAD -> alu_gnt=1 in cycle N; wr_en=1, wr_addr=5, wr_data=0xDEAD in N+1; wr_en=0 in N+2.
- Contention and starvation, STARVE_LIMIT=3: both requesters held continuously -> mem granted 3 cycles, ALU granted on the 4th, counter back to 0.
- Scoreboard: iss_valid with iss_rd=7, then rs1=7 -> hazard=1 until the commit of addr 7; hazard=0 in the commit cycle; busy[7]=0 after it.
- Same-edge set/clear: commit to reg 9 while iss_valid with iss_rd=9 -> busy[9] remains 1.
- Out-of-range: mem_req with mem_addr=28 -> mem_gnt=1, wr_en stays 0, busy_vec unchanged; rs2=28 -> hazard=0.
